// File: rtl/axis_video_pattern_gen.sv
// rtl/axis_video_pattern_gen.sv - AXI4-Stream video test pattern generator (line/frame timing, four patterns)
// Optional macro VIDEO_GEN_LFSR_EN replaces the mode 3 diagonal with a per-frame 16-bit LFSR pattern.
module axis_video_pattern_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 1,
   parameter int WIDTH      = 1280,
   parameter int HEIGHT     = 1024,
   parameter int H_GAP      = 0,
   parameter int V_GAP      = 0
) (
   input  logic                           i_sys_clk,
   input  logic                           i_sys_reset,
   input  logic                           i_enable,
   input  logic [1:0]                     i_mode,
   input  logic [DATA_WIDTH-1:0]          i_const_value,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tuser,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   output logic [15:0]                    o_frame_cnt,
   output logic                           o_busy
);

   localparam int XW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int YW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int GAP_MAX = (H_GAP > V_GAP) ? H_GAP : V_GAP;
   localparam int GW      = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_HGAP   = 2'd2;
   localparam logic [1:0] S_VGAP   = 2'd3;

   logic [1:0]            state;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [GW-1:0]         gap_cnt;
   logic [15:0]           frame_cnt;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] const_q;
   logic                  handshake;
   logic                  last_x;
   logic                  last_y;
   logic                  start_frame;
   logic [DATA_WIDTH-1:0] base;

   assign handshake = m_axis_tvalid & m_axis_tready;
   assign last_x    = (x == XW'(WIDTH - 1));
   assign last_y    = (y == YW'(HEIGHT - 1));

   // Every edge that launches a new frame; pattern settings are captured only here.
   assign start_frame = i_enable & (
                           (state == S_IDLE) |
                           ((state == S_VGAP) & (gap_cnt == '0)) |
                           ((state == S_ACTIVE) & handshake & last_x & last_y & (V_GAP == 0)));

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_reset) begin
         state     <= S_IDLE;
         x         <= '0;
         y         <= '0;
         gap_cnt   <= '0;
         frame_cnt <= '0;
         mode_q    <= '0;
         const_q   <= '0;
      end else begin
         if (start_frame) begin
            mode_q  <= i_mode;
            const_q <= i_const_value;
         end
         case (state)
            S_IDLE: begin
               if (i_enable) begin
                  state <= S_ACTIVE;
                  x     <= '0;
                  y     <= '0;
               end
            end
            S_ACTIVE: begin
               if (handshake) begin
                  if (!last_x) begin
                     x <= x + 1'b1;
                  end else begin
                     x <= '0;
                     if (!last_y) begin
                        y <= y + 1'b1;
                        if (H_GAP != 0) begin
                           state   <= S_HGAP;
                           gap_cnt <= GW'(H_GAP - 1);
                        end
                     end else begin
                        y         <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                        if (V_GAP != 0) begin
                           state   <= S_VGAP;
                           gap_cnt <= GW'(V_GAP - 1);
                        end else if (!i_enable) begin
                           state <= S_IDLE;
                        end
                     end
                  end
               end
            end
            S_HGAP: begin
               if (gap_cnt == '0) state <= S_ACTIVE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            S_VGAP: begin
               if (gap_cnt == '0) state <= i_enable ? S_ACTIVE : S_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef VIDEO_GEN_LFSR_EN
   logic [15:0] lfsr;

   // Fibonacci form, taps 16,14,13,11; reseeded so every frame repeats the same sequence.
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_reset || start_frame) lfsr <= 16'hACE1;
      else if (handshake)             lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end
`endif

   always_comb begin
      case (mode_q)
         2'd0:    base = DATA_WIDTH'(x);
         2'd1:    base = DATA_WIDTH'(y);
         2'd2:    base = const_q;
`ifdef VIDEO_GEN_LFSR_EN
         default: base = DATA_WIDTH'(lfsr);
`else
         default: base = DATA_WIDTH'(x) + DATA_WIDTH'(y) + DATA_WIDTH'(frame_cnt);
`endif
      endcase
      m_axis_tdata = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (m_axis_tvalid) m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = base + DATA_WIDTH'(c);
      end
   end

   assign m_axis_tvalid = (state == S_ACTIVE);
   assign m_axis_tuser  = m_axis_tvalid & (x == '0) & (y == '0);
   assign m_axis_tlast  = m_axis_tvalid & last_x;
   assign o_frame_cnt   = frame_cnt;
   assign o_busy        = (state != S_IDLE);

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// tb/tb_axis_video_pattern_gen.sv - self-checking bench for axis_video_pattern_gen (default build, mode 3 diagonal)
module tb_axis_video_pattern_gen;

   localparam int DW = 3;
   localparam int CH = 2;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int HG = 3;
   localparam int VG = 5;
   localparam int FB = W * H;

   typedef struct {
      logic [CH*DW-1:0] data;
      logic             user;
      logic             last;
      int               cyc;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [DW-1:0]    cval = '0;
   logic             tready = 1'b0;
   logic [CH*DW-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tuser;
   logic             m_axis_tlast;
   logic [15:0]      o_frame_cnt;
   logic             o_busy;

   int    n_checks = 0;
   int    n_fail = 0;
   int    cyc = 0;
   beat_t beats[$];

   axis_video_pattern_gen #(
      .DATA_WIDTH(DW), .CHANNELS(CH), .WIDTH(W), .HEIGHT(H), .H_GAP(HG), .V_GAP(VG)
   ) dut (
      .i_sys_clk     (clk),
      .i_sys_reset   (rst),
      .i_enable      (en),
      .i_mode        (mode),
      .i_const_value (cval),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (tready),
      .o_frame_cnt   (o_frame_cnt),
      .o_busy        (o_busy)
   );

   always #5 clk = ~clk;

   // Records every accepted beat with the cycle it was taken on.
   always @(posedge clk) begin
      cyc++;
      if (!rst && m_axis_tvalid && tready)
         beats.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast, cyc});
   end

   // Expected beat content from the pattern definition: value per channel = (pattern + c) mod 2^DW.
   function automatic logic [CH*DW-1:0] exp_data(int md, int cv, int px, int py, int fc);
      int v;
      logic [CH*DW-1:0] d;
      case (md)
         0:       v = px;
         1:       v = py;
         2:       v = cv;
         default: v = px + py + fc;
      endcase
      d = '0;
      for (int c = 0; c < CH; c++) d[c*DW +: DW] = DW'((v + c) % (1 << DW));
      return d;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(int n, int budget);
      for (int i = 0; i < budget && beats.size() < n; i++) cycle();
   endtask

   task automatic wait_idle(int budget);
      for (int i = 0; i < budget && o_busy; i++) cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b0;
      tready = 1'b0;
      repeat (3) cycle();
      n_checks += 6;
      if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
      if (m_axis_tuser !== 1'b0)  begin n_fail++; $display("FAIL reset_tuser: got %b expected 0", m_axis_tuser); end
      if (m_axis_tlast !== 1'b0)  begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
      if (m_axis_tdata !== '0)    begin n_fail++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
      if (o_busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      if (o_frame_cnt !== 16'd0)  begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", o_frame_cnt); end
      rst = 1'b0;
      cycle();
   endtask

   // Single mode-0 frame, enable dropped after beat 2: full frame still delivered, then idle.
   task automatic test_single_frame();
      beats.delete();
      mode = 2'd0;
      cval = '0;
      tready = 1'b1;
      en = 1'b1;
      wait_beats(2, 50);
      en = 1'b0;
      wait_idle(200);
      repeat (4) cycle();
      n_checks++;
      if (beats.size() != FB) begin n_fail++; $display("FAIL single_count: got %0d beats expected %0d", beats.size(), FB); end
      for (int k = 0; k < FB && k < beats.size(); k++) begin
         n_checks += 3;
         if (beats[k].data !== exp_data(0, 0, k % W, k / W, 0)) begin
            n_fail++; $display("FAIL single_tdata[%0d]: got %h expected %h", k, beats[k].data, exp_data(0, 0, k % W, k / W, 0));
         end
         if (beats[k].user !== (k == 0)) begin n_fail++; $display("FAIL single_tuser[%0d]: got %b expected %b", k, beats[k].user, k == 0); end
         if (beats[k].last !== (k % W == W - 1)) begin n_fail++; $display("FAIL single_tlast[%0d]: got %b expected %b", k, beats[k].last, k % W == W - 1); end
      end
      n_checks += 3;
      if (beats.size() > W && beats[W].cyc - beats[W-1].cyc != HG + 1) begin
         n_fail++; $display("FAIL single_hgap: got %0d idle expected %0d", beats[W].cyc - beats[W-1].cyc - 1, HG);
      end
      if (o_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_frame_cnt: got %0d expected 1", o_frame_cnt); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", o_busy); end
   endtask

   // Two continuous mode-1 frames under tready=1: exact gap lengths, otherwise one beat per cycle.
   task automatic test_back_to_back();
      int exp_gap;
      beats.delete();
      mode = 2'd1;
      tready = 1'b1;
      en = 1'b1;
      wait_beats(FB + 1, 100);
      en = 1'b0;
      wait_idle(200);
      n_checks++;
      if (beats.size() != 2 * FB) begin n_fail++; $display("FAIL b2b_count: got %0d beats expected %0d", beats.size(), 2 * FB); end
      for (int k = 0; k + 1 < beats.size(); k++) begin
         exp_gap = (k % FB == FB - 1) ? VG : ((k % W == W - 1) ? HG : 0);
         n_checks += 2;
         if (beats[k+1].cyc - beats[k].cyc - 1 != exp_gap) begin
            n_fail++; $display("FAIL b2b_gap[%0d]: got %0d idle expected %0d", k, beats[k+1].cyc - beats[k].cyc - 1, exp_gap);
         end
         if (beats[k].data !== exp_data(1, 0, k % W, (k % FB) / W, 0)) begin
            n_fail++; $display("FAIL b2b_tdata[%0d]: got %h expected %h", k, beats[k].data, exp_data(1, 0, k % W, (k % FB) / W, 0));
         end
      end
      n_checks++;
      if (o_frame_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_frame_cnt: got %0d expected 3", o_frame_cnt); end
   endtask

   // Three frames, random modes/const, 50% tready, junk settings driven mid-frame.
   task automatic test_random_backpressure();
      int fm[3];
      int fv[3];
      int n;
      int f;
      int r;
      logic stalled;
      logic [CH*DW-1:0] sd;
      logic su;
      logic sl;
      for (int i = 0; i < 3; i++) begin
         fm[i] = (i == 0) ? 3 : int'($urandom_range(0, 3));
         fv[i] = int'($urandom_range(0, (1 << DW) - 1));
      end
      beats.delete();
      mode = 2'(fm[0]);
      cval = DW'(fv[0]);
      en = 1'b1;
      stalled = 1'b0;
      for (int t = 0; t < 3000 && (beats.size() < 3 * FB || o_busy); t++) begin
         if (stalled) begin
            n_checks += 4;
            if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL stall_tvalid: got %b expected 1", m_axis_tvalid); end
            if (m_axis_tdata !== sd)    begin n_fail++; $display("FAIL stall_tdata: got %h expected %h", m_axis_tdata, sd); end
            if (m_axis_tuser !== su)    begin n_fail++; $display("FAIL stall_tuser: got %b expected %b", m_axis_tuser, su); end
            if (m_axis_tlast !== sl)    begin n_fail++; $display("FAIL stall_tlast: got %b expected %b", m_axis_tlast, sl); end
         end
         n = beats.size();
         if (n % FB != 0) begin
            mode = 2'($urandom);
            cval = DW'($urandom);
         end else if (n < 3 * FB) begin
            mode = 2'(fm[n / FB]);
            cval = DW'(fv[n / FB]);
         end
         if (n > 2 * FB) en = 1'b0;
         tready = 1'($urandom);
         stalled = m_axis_tvalid && !tready;
         sd = m_axis_tdata;
         su = m_axis_tuser;
         sl = m_axis_tlast;
         cycle();
      end
      tready = 1'b1;
      n_checks++;
      if (beats.size() != 3 * FB) begin n_fail++; $display("FAIL rand_count: got %0d beats expected %0d", beats.size(), 3 * FB); end
      for (int k = 0; k < 3 * FB && k < beats.size(); k++) begin
         f = k / FB;
         r = k % FB;
         n_checks += 3;
         if (beats[k].data !== exp_data(fm[f], fv[f], r % W, r / W, 3 + f)) begin
            n_fail++; $display("FAIL rand_tdata[%0d] mode %0d: got %h expected %h", k, fm[f], beats[k].data, exp_data(fm[f], fv[f], r % W, r / W, 3 + f));
         end
         if (beats[k].user !== (r == 0)) begin n_fail++; $display("FAIL rand_tuser[%0d]: got %b expected %b", k, beats[k].user, r == 0); end
         if (beats[k].last !== (r % W == W - 1)) begin n_fail++; $display("FAIL rand_tlast[%0d]: got %b expected %b", k, beats[k].last, r % W == W - 1); end
      end
      n_checks += 2;
      if (o_frame_cnt !== 16'd6) begin n_fail++; $display("FAIL rand_frame_cnt: got %0d expected 6", o_frame_cnt); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy: got %b expected 0", o_busy); end
   endtask

   // Reset pulsed mid-line: outputs clear after one edge, restart begins a fresh frame.
   task automatic test_reset_midline();
      beats.delete();
      mode = 2'd0;
      cval = '0;
      tready = 1'b1;
      en = 1'b1;
      wait_beats(2, 50);
      rst = 1'b1;
      cycle();
      n_checks += 5;
      if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %b expected 0", m_axis_tvalid); end
      if (m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
         n_fail++; $display("FAIL midrst_sideband: got user %b last %b expected 0 0", m_axis_tuser, m_axis_tlast);
      end
      if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL midrst_tdata: got %h expected 0", m_axis_tdata); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
      if (o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt: got %0d expected 0", o_frame_cnt); end
      cycle();
      beats.delete();
      rst = 1'b0;
      wait_beats(1, 50);
      n_checks++;
      if (beats.size() < 1) begin
         n_fail++; $display("FAIL midrst_restart: got 0 beats expected 1");
      end else begin
         n_checks++;
         if (beats[0].user !== 1'b1 || beats[0].data !== exp_data(0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL midrst_first_beat: got user %b data %h expected user 1 data %h", beats[0].user, beats[0].data, exp_data(0, 0, 0, 0, 0));
         end
      end
      en = 1'b0;
      wait_idle(200);
      n_checks += 2;
      if (beats.size() != FB) begin n_fail++; $display("FAIL midrst_count: got %0d beats expected %0d", beats.size(), FB); end
      if (o_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_frame_cnt_end: got %0d expected 1", o_frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_random_backpressure();
      test_reset_midline();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
